// File: rtl/data_sink_cycle_capture_pkg.sv
// rtl/data_sink_cycle_capture_pkg.sv - shared constants and state encoding for the period capture block
package data_sink_cycle_capture_pkg;

  localparam int MAX_PTS_DEF = 2048;
  localparam int ACC_W_DEF   = 32;
  localparam int SAMPLE_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    READOUT
  } state_t;

endpackage

// File: rtl/data_sink_cycle_capture_if.sv
// rtl/data_sink_cycle_capture_if.sv - source sample stream in, buffered word stream out
interface data_sink_cycle_capture_if
  import data_sink_cycle_capture_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) ();

  logic [31:0]      data_in;
  logic             data_in_valid;
  logic             zero_cross;
  logic             CE;
  logic [ACC_W-1:0] data_out;
  logic             data_out_valid;
  logic             data_out_ready;

  modport master (
    output data_in, data_in_valid, zero_cross, CE, data_out_ready,
    input  data_out, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, zero_cross, CE, data_out_ready,
    output data_out, data_out_valid
  );

endinterface

// File: rtl/data_sink_cycle_capture_ram.sv
// rtl/data_sink_cycle_capture_ram.sv - simple dual-port buffer RAM with registered, enabled read
module data_sink_cycle_capture_ram #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rdata only moves on re, so a stalled readout word stays put
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_sink_cycle_capture.sv
// rtl/data_sink_cycle_capture.sv - zero_cross aligned single-period capture and readout
// CAPTURE_AVG_EN builds coherent accumulation of ciclos periods.
module data_sink_cycle_capture
  import data_sink_cycle_capture_pkg::*;
#(
  parameter int MAX_PTS = MAX_PTS_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [15:0]                     ptos_x_ciclo,
  input  logic [15:0]                     ciclos,
  input  logic                            start,
  data_sink_cycle_capture_if.slave        bus,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);

  localparam int AW = $clog2(MAX_PTS);

  state_t state, state_nx;

  logic [AW-1:0]       m_last, idx;
  logic [AW:0]         rd_cnt;
  logic [15:0]         p_cnt, n_last;
  logic                accept, last_idx, sync_ok, cfg_bad, rd_pending, xfer;
  logic                cap_wr, period_end, lost_sync, rd_issue, last_xfer;
  logic                s1_valid;
  logic [AW-1:0]       s1_addr;
  logic [SAMPLE_W-1:0] s1_sample;
  logic                out_valid;
  logic                ram_re;
  logic [AW-1:0]       ram_raddr;
  logic [ACC_W-1:0]    ram_wdata, ram_rdata;
  logic                unused_inputs;

  assign accept     = bus.data_in_valid && bus.CE;
  assign last_idx   = (idx == m_last);
  assign sync_ok    = ((idx == '0) == bus.zero_cross);
  assign cfg_bad    = (ptos_x_ciclo == 16'd0) || ({16'd0, ptos_x_ciclo} > 32'(MAX_PTS));
  assign rd_pending = (rd_cnt <= {1'b0, m_last});
  assign xfer       = out_valid && bus.data_out_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    cap_wr     = 1'b0;
    lost_sync  = 1'b0;
    period_end = 1'b0;
    rd_issue   = 1'b0;
    last_xfer  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cfg_bad) state_nx = ARM;
      end
      ARM: begin
        cap_wr     = accept && bus.zero_cross;
        period_end = cap_wr && last_idx && (p_cnt == n_last);
        if (cap_wr) state_nx = period_end ? READOUT : CAPTURE;
      end
      CAPTURE: begin
        cap_wr     = accept && sync_ok;
        lost_sync  = accept && !sync_ok;
        period_end = cap_wr && last_idx && (p_cnt == n_last);
        if (lost_sync)       state_nx = IDLE;
        else if (period_end) state_nx = READOUT;
      end
      READOUT: begin
        // hold off while the final capture write is still in flight
        rd_issue  = rd_pending && !s1_valid && (!out_valid || bus.data_out_ready);
        last_xfer = xfer && !rd_pending;
        if (last_xfer) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_last    <= '0;
      n_last    <= '0;
      idx       <= '0;
      p_cnt     <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_sample <= '0;
    end else begin
      done      <= last_xfer;
      s1_valid  <= cap_wr;
      s1_addr   <= idx;
      s1_sample <= bus.data_in[SAMPLE_W-1:0];
      if (state == IDLE && start) begin
        error  <= cfg_bad;
        m_last <= AW'(ptos_x_ciclo - 16'd1);
`ifdef CAPTURE_AVG_EN
        n_last <= (ciclos == 16'd0) ? 16'd0 : ciclos - 16'd1;
`else
        n_last <= 16'd0;
`endif
        idx    <= '0;
        p_cnt  <= '0;
        rd_cnt <= '0;
      end
      if (lost_sync) error <= 1'b1;
      if (cap_wr) begin
        idx <= last_idx ? '0 : idx + AW'(1);
        if (last_idx) p_cnt <= p_cnt + 16'd1;
      end
      if (rd_issue)  begin
        rd_cnt    <= rd_cnt + 1'b1;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CAPTURE_AVG_EN
  logic             s1_acc, fwd_valid;
  logic [ACC_W-1:0] fwd_data, rmw_old;

  // M=1 reads the address being written on the same edge; take the pending sum instead
  assign rmw_old   = fwd_valid ? fwd_data : ram_rdata;
  assign ram_wdata = (s1_acc ? rmw_old : '0) + ACC_W'(s1_sample);
  assign ram_re    = rd_issue || cap_wr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_acc    <= 1'b0;
      fwd_valid <= 1'b0;
      fwd_data  <= '0;
    end else begin
      s1_acc    <= (p_cnt != 16'd0);
      fwd_valid <= cap_wr && s1_valid && (idx == s1_addr);
      fwd_data  <= ram_wdata;
    end
  end

  assign unused_inputs = ^bus.data_in[31:SAMPLE_W];
`else
  assign ram_wdata     = ACC_W'(s1_sample);
  assign ram_re        = rd_issue;
  assign unused_inputs = ^{bus.data_in[31:SAMPLE_W], ciclos};
`endif

  assign ram_raddr = (state == READOUT) ? rd_cnt[AW-1:0] : idx;

  data_sink_cycle_capture_ram #(
    .DEPTH (MAX_PTS),
    .WIDTH (ACC_W),
    .AW    (AW)
  ) capture_ram (
    .clock (clock),
    .we    (s1_valid),
    .waddr (s1_addr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign bus.data_out       = out_valid ? ram_rdata : '0;
  assign bus.data_out_valid = out_valid;

endmodule

// File: tb/tb_data_sink_cycle_capture.sv
// tb/tb_data_sink_cycle_capture.sv - directed bench for data_sink_cycle_capture
module tb_data_sink_cycle_capture;

  typedef struct {
    logic [15:0] val;
    bit          zc;
  } stim_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ptos_x_ciclo = '0;
  logic [15:0] ciclos = '0;
  logic        busy, done, error;

  int          n_pass = 0;
  int          n_checks = 0;
  stim_t       stim_q[$];
  logic [31:0] exp_q[$];
  int          fin_idx;
  logic [15:0] ready_pat = 16'hB2E5;

  data_sink_cycle_capture_if #(.ACC_W(32)) bus ();

  data_sink_cycle_capture dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ptos_x_ciclo (ptos_x_ciclo),
    .ciclos       (ciclos),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.data_in        = '0;
    bus.data_in_valid  = 1'b0;
    bus.zero_cross     = 1'b0;
    bus.CE             = 1'b1;
    bus.data_out_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " data_out"}, bus.data_out, 32'd0);
    check({tag, " valid"}, 32'(bus.data_out_valid), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " error"}, 32'(error), 32'd0);
  endtask

  task automatic do_start(input string tag, input int m, input int n, input bit exp_err);
    ptos_x_ciclo = 16'(m);
    ciclos       = 16'(n);
    start        = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " start busy"}, 32'(busy), 32'(!exp_err));
    check({tag, " start error"}, 32'(error), 32'(exp_err));
  endtask

  task automatic new_case();
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic push_stim(input int v, input bit zc);
    stim_t s;
    s.val = 16'(v);
    s.zc  = zc;
    stim_q.push_back(s);
  endtask

  // Feeds stim_q (one sample every `period` clocks, off-cycles strobe with CE low)
  // and collects the readout against exp_q.
  task automatic run_stream(input string tag, input int period, input bit rand_ready, input bit expect_abort);
    int          si, wi, cyc, fin_iter, first_valid, done_iter;
    bit          stalled, valid_seen, finished;
    logic [31:0] held;
    si = 0; wi = 0; cyc = 0; fin_iter = -1; first_valid = -1; done_iter = -1;
    stalled = 0; valid_seen = 0; finished = 0; held = '0;
    while (!finished && cyc < 3000) begin
      if (si < stim_q.size() && (cyc % period) == 0) begin
        bus.data_in       = {16'hA5C3, stim_q[si].val};
        bus.data_in_valid = 1'b1;
        bus.CE            = 1'b1;
        bus.zero_cross    = stim_q[si].zc;
        if (si == fin_idx) fin_iter = cyc;
        si++;
      end else begin
        bus.data_in       = 32'h0000_7777;
        bus.data_in_valid = (period > 1);
        bus.CE            = 1'b0;
        bus.zero_cross    = (period > 1);
      end
      bus.data_out_ready = rand_ready ? ready_pat[cyc % 16] : 1'b1;

      if (stalled) begin
        check({tag, " valid held"}, 32'(bus.data_out_valid), 32'd1);
        check({tag, " stable"}, bus.data_out, held);
      end
      stalled = 0;
      if (bus.data_out_valid) begin
        valid_seen = 1;
        if (first_valid < 0) first_valid = cyc;
        held    = bus.data_out;
        stalled = !bus.data_out_ready;
        if (bus.data_out_ready) begin
          if (wi < exp_q.size()) check($sformatf("%s word%0d", tag, wi), bus.data_out, exp_q[wi]);
          else check({tag, " extra word"}, 32'(wi), 32'(exp_q.size()));
          wi++;
        end
      end
      if (done) begin
        done_iter = cyc;
        finished  = 1;
        check({tag, " busy at done"}, 32'(busy), 32'd0);
      end
      if (expect_abort && cyc >= stim_q.size() * period + 6) finished = 1;
      tick();
      cyc++;
    end
    idle_inputs();

    if (expect_abort) begin
      check({tag, " no valid"}, 32'(valid_seen), 32'd0);
      check({tag, " no done"}, 32'(done_iter < 0), 32'd1);
      check({tag, " error"}, 32'(error), 32'd1);
      check({tag, " busy"}, 32'(busy), 32'd0);
    end else begin
      check({tag, " done seen"}, 32'(done_iter >= 0), 32'd1);
      check({tag, " words"}, 32'(wi), 32'(exp_q.size()));
      check({tag, " latency"}, 32'(first_valid > fin_iter && first_valid - fin_iter <= 3), 32'd1);
      if (!rand_ready)
        check({tag, " throughput"}, 32'(done_iter - first_valid), 32'(exp_q.size()));
      check({tag, " done pulse"}, 32'(done), 32'd0);
      check({tag, " error"}, 32'(error), 32'd0);
    end
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // ramp with two pre-zero_cross samples that ARM must discard
    do_start("t1", 8, 1, 1'b0);
    new_case();
    push_stim(5, 1'b0);
    push_stim(6, 1'b0);
    for (int k = 0; k < 8; k++) begin
      push_stim(100 + k, k == 0);
      exp_q.push_back(32'(100 + k));
    end
    fin_idx = 9;
    run_stream("t1", 1, 1'b0, 1'b0);

    // three periods, one sample every third clock
    do_start("t2", 4, 3, 1'b0);
    new_case();
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 4; k++) push_stim(10 + k, k == 0);
`ifdef CAPTURE_AVG_EN
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(3 * (10 + k)));
    fin_idx = 11;
`else
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(10 + k));
    fin_idx = 3;
`endif
    run_stream("t2", 3, 1'b0, 1'b0);

    // single-point period, back-to-back to the same address
    do_start("t3", 1, 5, 1'b0);
    new_case();
    for (int k = 0; k < 5; k++) push_stim(7, 1'b1);
`ifdef CAPTURE_AVG_EN
    exp_q.push_back(32'd35);
    fin_idx = 4;
`else
    exp_q.push_back(32'd7);
    fin_idx = 0;
`endif
    run_stream("t3", 1, 1'b0, 1'b0);

    // zero_cross arriving at index 2
    do_start("t4", 4, 1, 1'b0);
    new_case();
    push_stim(10, 1'b1);
    push_stim(11, 1'b0);
    push_stim(12, 1'b1);
    fin_idx = -1;
    run_stream("t4", 1, 1'b0, 1'b1);

`ifdef CAPTURE_AVG_EN
    // second period starts without zero_cross
    do_start("t5", 4, 2, 1'b0);
    new_case();
    for (int k = 0; k < 4; k++) push_stim(10 + k, k == 0);
    push_stim(20, 1'b0);
    fin_idx = -1;
    run_stream("t5", 1, 1'b0, 1'b1);
`endif

    // stalling downstream
    do_start("t6", 16, 1, 1'b0);
    new_case();
    for (int k = 0; k < 16; k++) begin
      push_stim(1000 + 37 * k, k == 0);
      exp_q.push_back(32'(1000 + 37 * k));
    end
    fin_idx = 15;
    run_stream("t6", 1, 1'b1, 1'b0);

    // bad configurations
    do_start("m0", 0, 1, 1'b1);
    tick();
    check("m0 busy later", 32'(busy), 32'd0);
    do_start("m2049", 2049, 1, 1'b1);
    tick();
    check("m2049 busy later", 32'(busy), 32'd0);
    check("m2049 error sticky", 32'(error), 32'd1);

    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst err");
    tick();
    reset_n = 1'b1;
    tick();

    // largest legal period, reset part-way through capture
    do_start("m2048", 2048, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      bus.data_in       = 32'(50 + k);
      bus.data_in_valid = 1'b1;
      bus.zero_cross    = (k == 0);
      tick();
    end
    idle_inputs();
    check("m2048 capturing", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst mid");
    tick();
    reset_n = 1'b1;
    tick();
    check("post rst idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_sink_cycle_capture.md
# data_sink_cycle_capture

Period-synchronous capture block for the sample stream produced by the DAC/ADC data sources. It aligns to the source's `zero_cross` marker, stores exactly one signal period of `ptos_x_ciclo` samples, and (optionally) coherently accumulates N consecutive periods into the same buffer. The result is then streamed out with a valid/ready handshake to the analysis or host-readout path. It sits directly downstream of a data source, consuming the same `data`/`data_valid`/`zero_cross`/`CE` interface.

## Interface
- `MAX_PTS`, 2048: buffer depth; maximum accepted `ptos_x_ciclo`.
- `ACC_W`, 32: accumulator and output word width.
- `clock` in 1: single clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `CE` in 1: sample enable; samples are accepted only while high.
- `ptos_x_ciclo` in 16: samples per signal period (M); latched on `start`.
- `ciclos` in 16: periods to accumulate (N); latched on `start`; 0 is treated as 1.
- `start` in 1: one-clock request to begin a capture; ignored unless IDLE.
- `data_in` in 32: sample from the source; bits [15:0] are used, unsigned.
- `data_in_valid` in 1: sample strobe.
- `zero_cross` in 1: period-start marker, coincident with sample index 0.
- `data_out` out ACC_W: buffered word, zero-extended.
- `data_out_valid` out 1: readout word valid.
- `data_out_ready` in 1: downstream accept.
- `busy` out 1: high in every state other than IDLE.
- `done` out 1: one-clock pulse after the last word is accepted.
- `error` out 1: sticky; set on bad config or lost sync; cleared by the next accepted `start`.

## Operation
- A sample counts only when `data_in_valid && CE`.
- **IDLE**
  - `start` latches M and N and clears the index (i) and the period counter (p).
  - If M is 0 or M > MAX_PTS: set `error` and stay in IDLE.
  - Otherwise go to ARM.
- **ARM**
  - Discard samples until one arrives with `zero_cross` high.
  - That sample is written to buf[0] with i=1, and the state moves to CAPTURE.
- **CAPTURE**
  - On each sample, write buf[i]. Period 0 stores the sample; later periods store buf[i] + sample.
  - i wraps M-1 → 0. On wrap, p increments.
  - When the sample at i=M-1 arrives with p=N-1, go to READOUT.
  - At i=0 with p>0, `zero_cross` must be high. If not, set `error` and go to IDLE with no readout.
  - `zero_cross` seen while i≠0: set `error` and go to IDLE.
- **READOUT**
  - Present buf[0..M-1] in order.
  - A word transfers on `data_out_valid && data_out_ready`.
  - After word M-1 transfers, pulse `done` and go to IDLE.
- **Read-modify-write**
  - Must sustain one sample per clock, including back-to-back accumulation to the same address when M=1 (forward the pending write).
- **Widths**
  - Sum is at most N·(2^16−1), which is < 2^32 for N ≤ 65535.
  - Arithmetic is unsigned; no saturation is needed.
- **Mid-operation events**
  - `start` while busy: ignored.
  - `reset_n` asserted mid-operation: return to IDLE immediately.
  - Buffer contents are undefined after reset.

## Timing
- **Reset values**
  - `data_out`=0, `data_out_valid`=0, `busy`=0, `done`=0, `error`=0.
  - State = IDLE.
- **Start**
  - `busy` rises the clock after an accepted `start`.
- **Capture**
  - No sample is lost at any input rate up to one per clock.
- **Readout latency**
  - First `data_out_valid` occurs at most 2 clocks after the final sample is accepted.
  - After an accepted word, the next word is valid within 1 clock, giving full throughput with `ready` held high.
- **Handshake**
  - While `data_out_valid && !data_out_ready`, `data_out` holds stable.
- **Done**
  - `done` pulses the clock after the last transfer.
  - `busy` falls in the same clock as `done`.

## Configuration
- `CAPTURE_AVG_EN`
  - **Defined:** multi-period accumulation as described above.
  - **Undefined:**
    - `ciclos` is ignored and N=1; the RMW path and forwarding logic are not built.
    - The lost-sync check applies only inside the single period.
    - `data_out` is the stored sample, zero-extended.

## Structure
- **Shared package:** state enum (IDLE, ARM, CAPTURE, READOUT), MAX_PTS, and the sample and accumulator width constants.
- **Sub-module:** `capture_ram`, a simple dual-port RAM of MAX_PTS × ACC_W with 1-clock registered read.
  - The write port is used by CAPTURE.
  - The read port is shared by RMW and READOUT.

## Test plan
- M=8, N=1, ramp samples 100..107, first with `zero_cross`, valid every clock, `ready`=1.
  - Expect outputs 100..107, then a `done` pulse; `error`=0.
- M=4, N=3 (AVG_EN defined), sample k of each period = 10+k, valid every 3rd clock with `CE`=1.
  - Expect outputs 30,33,36,39.
- M=1, N=5, constant 7 every clock.
  - Expect a single output of 35, which exercises same-address forwarding.
- M=4, N=2, second period's index-0 sample arrives without `zero_cross`.
  - Expect `error`=1, return to IDLE, no `data_out_valid`.
- M=16, `ready` toggled pseudo-randomly.
  - Expect 16 words in order, each stable while stalled.
- `ptos_x_ciclo`=0, then 2049.
  - Expect `error` each time and `busy` staying 0.
- Assert `reset_n` mid-CAPTURE.
  - Expect all outputs at reset values.
